// File: rtl/pipe_hazard_ctrl_if.sv
// Host/pipeline-side signal bundle for pipe_hazard_ctrl; counter ports exist only with HAZARD_PERF_CNT_EN.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PERF_CNT_WIDTH = 32
);
  logic                      run;
  logic                      step;
  logic [REG_ADDR_WIDTH-1:0] id_rs;
  logic [REG_ADDR_WIDTH-1:0] id_rt;
  logic                      id_rs_used;
  logic                      id_rt_used;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_mem_read;
  logic                      id_branch_taken;
  logic                      mem_busy;
  logic                      pc_en;
  logic                      if_id_en;
  logic                      if_id_flush;
  logic                      id_ex_bubble;
  logic                      pipe_en;
  logic [1:0]                state;
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_WIDTH-1:0] stall_cnt;
  logic [PERF_CNT_WIDTH-1:0] flush_cnt;
`endif

  modport master (
    output run, step, id_rs, id_rt, id_rs_used, id_rt_used, ex_rd, ex_mem_read,
           id_branch_taken, mem_busy,
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cnt, flush_cnt,
`endif
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en, state
  );

  modport slave (
    input  run, step, id_rs, id_rt, id_rs_used, id_rt_used, ex_rd, ex_mem_read,
           id_branch_taken, mem_busy,
`ifdef HAZARD_PERF_CNT_EN
    output stall_cnt, flush_cnt,
`endif
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/run controller for the 5-stage pipe; outputs are combinational from state and inputs.
// HAZARD_PERF_CNT_EN adds saturating load-use stall and branch flush counters.
module pipe_hazard_ctrl (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t state_q;

  logic active;
  logic load_use;
  logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_bubble_c, pipe_en_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HALT;
    end else begin
      case (state_q)
        ST_RUN:  if (!bus.run) state_q <= ST_HALT;
        ST_HALT: begin
          if (bus.run)       state_q <= ST_RUN;
          else if (bus.step) state_q <= ST_STEP;
        end
        ST_STEP: state_q <= bus.run ? ST_RUN : ST_HALT;
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign active   = (state_q == ST_RUN) || (state_q == ST_STEP);
  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = bus.ex_mem_read && (bus.ex_rd != '0) &&
                    ((bus.id_rs_used && (bus.id_rs == bus.ex_rd)) ||
                     (bus.id_rt_used && (bus.id_rt == bus.ex_rd)));

  always_comb begin
    pc_en_c        = 1'b0;
    if_id_en_c     = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    pipe_en_c      = 1'b0;
    if (reset) begin
      if_id_flush_c  = 1'b1;
      id_ex_bubble_c = 1'b1;
    end else if (active) begin
      if (bus.mem_busy) begin
        // whole pipe holds
      end else if (load_use) begin
        pipe_en_c      = 1'b1;
        id_ex_bubble_c = 1'b1;
      end else if (bus.id_branch_taken) begin
        pc_en_c       = 1'b1;
        if_id_en_c    = 1'b1;
        if_id_flush_c = 1'b1;
        pipe_en_c     = 1'b1;
      end else begin
        pc_en_c    = 1'b1;
        if_id_en_c = 1'b1;
        pipe_en_c  = 1'b1;
      end
    end
  end

  assign bus.pc_en        = pc_en_c;
  assign bus.if_id_en     = if_id_en_c;
  assign bus.if_id_flush  = if_id_flush_c;
  assign bus.id_ex_bubble = id_ex_bubble_c;
  assign bus.pipe_en      = pipe_en_c;
  assign bus.state        = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_inc, flush_inc;
  assign stall_inc = active && load_use && !bus.mem_busy;
  assign flush_inc = active && if_id_flush_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      if (stall_inc && (bus.stall_cnt != '1)) bus.stall_cnt <= bus.stall_cnt + 1'b1;
      if (flush_inc && (bus.flush_cnt != '1)) bus.flush_cnt <= bus.flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; ctl packs {pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_en}.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] ctl;
  assign ctl = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_bubble, bus.pipe_en};

  localparam logic [4:0] C_RST   = 5'b00110;
  localparam logic [4:0] C_OFF   = 5'b00000;
  localparam logic [4:0] C_RUN   = 5'b11001;
  localparam logic [4:0] C_STALL = 5'b00011;
  localparam logic [4:0] C_FLUSH = 5'b11101;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock edge, leaving time at negedge
  task automatic next;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.run = 1'b0;             bus.step = 1'b0;
    bus.id_rs = '0;             bus.id_rt = '0;
    bus.id_rs_used = 1'b0;      bus.id_rt_used = 1'b0;
    bus.ex_rd = '0;             bus.ex_mem_read = 1'b0;
    bus.id_branch_taken = 1'b0; bus.mem_busy = 1'b0;

    // reset held 3 cycles
    repeat (3) next();
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_state", 32'(bus.state), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
    chk("rst_flush_cnt", bus.flush_cnt, 32'd0);
`endif
    reset = 1'b0;
    #1;
    chk("halt_ctl", 32'(ctl), 32'(C_OFF));
    bus.run = 1'b1;
    next(); #1;
    chk("run_state", 32'(bus.state), 32'd0);
    chk("run_ctl", 32'(ctl), 32'(C_RUN));

    // load-use on rs
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd3; bus.id_rs = 5'd3; bus.id_rs_used = 1'b1;
    #1;
    chk("lu_rs_ctl", 32'(ctl), 32'(C_STALL));
    next(); bus.ex_mem_read = 1'b0; #1;
    chk("lu_resume_ctl", 32'(ctl), 32'(C_RUN));
`ifdef HAZARD_PERF_CNT_EN
    chk("lu_stall_cnt", bus.stall_cnt, 32'd1);
`endif

    // taken branch alone
    bus.id_branch_taken = 1'b1; #1;
    chk("br_ctl", 32'(ctl), 32'(C_FLUSH));
    next(); bus.id_branch_taken = 1'b0; #1;
    chk("br_after_ctl", 32'(ctl), 32'(C_RUN));
`ifdef HAZARD_PERF_CNT_EN
    chk("br_flush_cnt", bus.flush_cnt, 32'd1);
`endif

    // load-use and branch together: stall wins, branch re-evaluated next cycle
    bus.ex_mem_read = 1'b1; bus.id_branch_taken = 1'b1; #1;
    chk("lu_br_ctl", 32'(ctl), 32'(C_STALL));
    next(); bus.ex_mem_read = 1'b0; #1;
    chk("lu_br_next_ctl", 32'(ctl), 32'(C_FLUSH));
    next(); bus.id_branch_taken = 1'b0; #1;
    chk("lu_br_done_ctl", 32'(ctl), 32'(C_RUN));
`ifdef HAZARD_PERF_CNT_EN
    chk("lu_br_stall_cnt", bus.stall_cnt, 32'd2);
    chk("lu_br_flush_cnt", bus.flush_cnt, 32'd2);
`endif

    // rt match only counts when rt is used
    bus.id_rs_used = 1'b0; bus.id_rs = 5'd7; bus.id_rt = 5'd3; bus.ex_mem_read = 1'b1; #1;
    chk("rt_unused_ctl", 32'(ctl), 32'(C_RUN));
    bus.id_rt_used = 1'b1; #1;
    chk("rt_used_ctl", 32'(ctl), 32'(C_STALL));

    // mem_busy overrides a load-use and does not count as a stall
    bus.mem_busy = 1'b1; #1;
    chk("busy_ctl", 32'(ctl), 32'(C_OFF));
    next(); bus.mem_busy = 1'b0; bus.ex_mem_read = 1'b0; bus.id_rt_used = 1'b0; #1;
    chk("busy_state", 32'(bus.state), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("busy_stall_cnt", bus.stall_cnt, 32'd2);
`endif

    // halt, then single step
    bus.run = 1'b0; #1;
    chk("halt_req_ctl", 32'(ctl), 32'(C_RUN));
    next(); #1;
    chk("halt_state", 32'(bus.state), 32'd1);
    chk("halt_frozen_ctl", 32'(ctl), 32'(C_OFF));
    bus.step = 1'b1;
    next(); bus.step = 1'b0; #1;
    chk("step_state", 32'(bus.state), 32'd2);
    chk("step_ctl", 32'(ctl), 32'(C_RUN));
    next(); #1;
    chk("step_back_state", 32'(bus.state), 32'd1);
    chk("step_back_ctl", 32'(ctl), 32'(C_OFF));

    // step consumed by mem_busy
    bus.step = 1'b1;
    next(); bus.step = 1'b0; bus.mem_busy = 1'b1; #1;
    chk("step_busy_state", 32'(bus.state), 32'd2);
    chk("step_busy_ctl", 32'(ctl), 32'(C_OFF));
    next(); bus.mem_busy = 1'b0; #1;
    chk("step_busy_back_state", 32'(bus.state), 32'd1);

    // load to r0 never stalls, then reset mid-stall
    bus.run = 1'b1;
    next(); #1;
    chk("rerun_state", 32'(bus.state), 32'd0);
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_rs_used = 1'b1; #1;
    chk("r0_ctl", 32'(ctl), 32'(C_RUN));
    bus.ex_rd = 5'd3; bus.id_rs = 5'd3; #1;
    chk("pre_rst_stall_ctl", 32'(ctl), 32'(C_STALL));
    reset = 1'b1; #1;
    chk("mid_rst_ctl", 32'(ctl), 32'(C_RST));
    chk("mid_rst_state", 32'(bus.state), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    chk("mid_rst_stall_cnt", bus.stall_cnt, 32'd0);
`endif
    next();
    reset = 1'b0; bus.ex_mem_read = 1'b0; #1;
    chk("post_rst_ctl", 32'(ctl), 32'(C_OFF));
    next(); #1;
    chk("post_rst_run_state", 32'(bus.state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
